// File: rtl/stack_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stack_op_sequencer                                              |
// | Brief    : Stack-machine instruction front-end. Accepts 3-bit ops over a   |
// |            valid/ready handshake and sequences them into single-cycle      |
// |            strobes for a two-slot operand stack, computes ALU results from |
// |            the stack's registered outputs, tracks depth, flags errors.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stack_op_sequencer #(
    parameter int W = 8,
    parameter int D = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_imm,
    input  logic [W-1:0] top_val,
    input  logic [W-1:0] pen_val,
    output logic         push_top,
    output logic         push_pen,
    output logic         pop_top,
    output logic         pop_pen,
    output logic [W-1:0] push_top_data,
    output logic [W-1:0] push_pen_data,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic [D:0]   depth,
    output logic         err,
    input  logic         err_clr
);

    localparam logic [D:0] c_DMAX = (D+1)'(2**D);
    localparam logic [D:0] c_ONE  = (D+1)'(1);
    localparam logic [D:0] c_TWO  = (D+1)'(2);

    localparam logic [2:0] c_OP_NOP  = 3'd0;
    localparam logic [2:0] c_OP_PUSH = 3'd1;
    localparam logic [2:0] c_OP_POP  = 3'd2;
    localparam logic [2:0] c_OP_ADD  = 3'd3;
    localparam logic [2:0] c_OP_SUB  = 3'd4;
    localparam logic [2:0] c_OP_AND  = 3'd5;
    localparam logic [2:0] c_OP_XOR  = 3'd6;
    localparam logic [2:0] c_OP_DUP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_POP_T = 3'd2,
        S_POP_P = 3'd3,
        S_WAIT  = 3'd4,
        S_EXEC  = 3'd5,
        S_DUP_A = 3'd6,
        S_DUP_B = 3'd7
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [2:0]   r_op;
    logic [W-1:0] r_imm;
    logic [W-1:0] r_hold;
    logic [W-1:0] r_res;
    logic [W-1:0] w_alu;
    logic         w_accept;
    logic         w_legal;
    logic         w_r_alu;

    assign w_accept      = in_valid && (r_state == S_IDLE);
    assign w_r_alu       = (r_op == c_OP_ADD) || (r_op == c_OP_SUB) ||
                           (r_op == c_OP_AND) || (r_op == c_OP_XOR);
    assign push_pen      = 1'b0;
    assign push_pen_data = '0;

    // Legality of the offered op against the current depth
    always_comb begin
        w_legal = 1'b0;
        case (in_op)
            c_OP_NOP:  w_legal = 1'b1;
            c_OP_PUSH: w_legal = (depth != c_DMAX);
            c_OP_POP:  w_legal = (depth >= c_ONE);
            c_OP_ADD,
            c_OP_SUB,
            c_OP_AND,
            c_OP_XOR:  w_legal = (depth >= c_TWO);
            c_OP_DUP:  w_legal = (depth >= c_ONE) && (depth != c_DMAX);
            default:   w_legal = 1'b0;
        endcase
    end

    // Result of the captured op from the stack's registered outputs; POP passes top through
    always_comb begin
        w_alu = top_val;
        case (r_op)
            c_OP_ADD: w_alu = pen_val + top_val;
            c_OP_SUB: w_alu = pen_val - top_val;
            c_OP_AND: w_alu = pen_val & top_val;
            c_OP_XOR: w_alu = pen_val ^ top_val;
            default:  w_alu = top_val;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobe decode of the registered state
    always_comb begin
        w_next        = r_state;
        in_ready      = 1'b0;
        push_top      = 1'b0;
        pop_top       = 1'b0;
        pop_pen       = 1'b0;
        push_top_data = '0;
        res_valid     = 1'b0;
        res_data      = r_res;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept && w_legal) begin
                    if (in_op == c_OP_PUSH) begin
                        w_next = S_PUSH;
                    end else if (in_op != c_OP_NOP) begin
                        w_next = S_POP_T;
                    end
                end
            end
            S_PUSH: begin
                push_top      = 1'b1;
                push_top_data = r_imm;
                w_next        = S_IDLE;
            end
            S_POP_T: begin
                pop_top = 1'b1;
                w_next  = w_r_alu ? S_POP_P : S_WAIT;
            end
            S_POP_P: begin
                pop_pen = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                w_next = (r_op == c_OP_DUP) ? S_DUP_A : S_EXEC;
            end
            S_EXEC: begin
                res_valid = 1'b1;
                res_data  = w_alu;
                if (w_r_alu) begin
                    push_top      = 1'b1;
                    push_top_data = w_alu;
                end
                w_next = S_IDLE;
            end
            S_DUP_A: begin
                push_top      = 1'b1;
                push_top_data = top_val;
                w_next        = S_DUP_B;
            end
            S_DUP_B: begin
                push_top      = 1'b1;
                push_top_data = r_hold;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture op/immediate at acceptance, hold DUP value and last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= c_OP_NOP;
            r_imm  <= '0;
            r_hold <= '0;
            r_res  <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= in_op;
                r_imm <= in_imm;
            end
            if (r_state == S_DUP_A) begin
                r_hold <= top_val;
            end
            if (r_state == S_EXEC) begin
                r_res <= w_alu;
            end
        end
    end

    // Depth follows each strobe on the edge that ends it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else begin
            case (r_state)
                S_PUSH, S_DUP_A, S_DUP_B: depth <= depth + c_ONE;
                S_EXEC:                   if (w_r_alu) depth <= depth + c_ONE;
                S_POP_T, S_POP_P:         depth <= depth - c_ONE;
                default:                  depth <= depth;
            endcase
        end
    end

    // Sticky error: an illegal acceptance wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (w_accept && !w_legal) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stack_op_sequencer                                           |
// | Brief    : Self-checking bench for stack_op_sequencer with a behavioural   |
// |            operand-stack environment and a queue-based reference model.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_stack_op_sequencer;

    localparam int W    = 8;
    localparam int D    = 5;
    localparam int DMAX = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         err_clr = 1'b0;
    logic [2:0]   in_op = 3'd0;
    logic [W-1:0] in_imm = '0;
    logic [W-1:0] top_val;
    logic [W-1:0] pen_val;
    logic         in_ready, push_top, push_pen, pop_top, pop_pen, res_valid, err;
    logic [W-1:0] push_top_data, push_pen_data, res_data;
    logic [D:0]   depth;

    int vectors = 0;
    int miscompares = 0;

    // Observed/expected activity of one instruction; trace holds one octal digit
    // per busy cycle: {pop_pen, pop_top, push_top}
    typedef struct packed {
        logic [3:0]   busy;
        logic [11:0]  trace;
        logic [1:0]   npush;
        logic [W-1:0] pd0;
        logic [W-1:0] pd1;
        logic [1:0]   nres;
        logic [W-1:0] rdata;
        logic         multi;
    } obs_t;

    always #5 clk = ~clk;

    stack_op_sequencer #(.W(W), .D(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_imm(in_imm), .top_val(top_val), .pen_val(pen_val),
        .push_top(push_top), .push_pen(push_pen), .pop_top(pop_top), .pop_pen(pop_pen),
        .push_top_data(push_top_data), .push_pen_data(push_pen_data),
        .res_valid(res_valid), .res_data(res_data), .depth(depth), .err(err),
        .err_clr(err_clr)
    );

    // Downstream operand stack: popped entries appear on top_val/pen_val registers
    logic [W-1:0] env_q[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q.delete();
            top_val <= '0;
            pen_val <= '0;
        end else if (pop_top) begin
            top_val <= (env_q.size() > 0) ? env_q[$] : '0;
            if (env_q.size() > 0) void'(env_q.pop_back());
        end else if (pop_pen) begin
            pen_val <= (env_q.size() > 0) ? env_q[$] : '0;
            if (env_q.size() > 0) void'(env_q.pop_back());
        end else if (push_top) begin
            env_q.push_back(push_top_data);
        end
    end

    // Count push strobes for the back-to-back scenario
    int push_cnt = 0;
    always @(negedge clk) begin
        if (push_top) push_cnt <= push_cnt + 1;
    end

    // Reference model state
    logic [W-1:0] ref_q[$];
    logic         ref_err = 1'b0;
    logic [W-1:0] ref_res = '0;

    task automatic model(input logic [2:0] op, input logic [W-1:0] imm, input logic clr,
                         output obs_t e);
        int n;
        bit legal;
        logic [W-1:0] a, b, r;
        n = ref_q.size();
        e = '0;
        case (op)
            3'd0:    legal = 1'b1;
            3'd1:    legal = (n < DMAX);
            3'd2:    legal = (n >= 1);
            3'd7:    legal = (n >= 1) && (n < DMAX);
            default: legal = (n >= 2);
        endcase
        if (!legal) begin
            ref_err = 1'b1;
            return;
        end
        if (clr) ref_err = 1'b0;
        case (op)
            3'd0: ;
            3'd1: begin
                ref_q.push_back(imm);
                e.busy = 4'd1; e.trace = 12'o0001; e.npush = 2'd1; e.pd0 = imm;
            end
            3'd2: begin
                b = ref_q.pop_back();
                ref_res = b;
                e.busy = 4'd3; e.trace = 12'o0200; e.nres = 2'd1; e.rdata = b;
            end
            3'd7: begin
                b = ref_q[$];
                ref_q.push_back(b);
                e.busy = 4'd4; e.trace = 12'o2011; e.npush = 2'd2; e.pd0 = b; e.pd1 = b;
            end
            default: begin
                b = ref_q.pop_back();
                a = ref_q.pop_back();
                case (op)
                    3'd3:    r = a + b;
                    3'd4:    r = a - b;
                    3'd5:    r = a & b;
                    default: r = a ^ b;
                endcase
                ref_q.push_back(r);
                ref_res = r;
                e.busy = 4'd4; e.trace = 12'o2401; e.npush = 2'd1; e.pd0 = r;
                e.nres = 2'd1; e.rdata = r;
            end
        endcase
    endtask

    // Issue one instruction and record every cycle until the sequencer is idle again
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] imm, input logic clr,
                          output obs_t o);
        logic [2:0] code;
        int guard;
        o = '0;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_op = op; in_imm = imm; in_valid = 1'b1; err_clr = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0; err_clr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (in_ready) break;
            o.busy = o.busy + 4'd1;
            code = {pop_pen, pop_top, push_top};
            o.trace = {o.trace[8:0], code};
            if (push_top) begin
                if (o.npush == 2'd0) o.pd0 = push_top_data;
                else                 o.pd1 = push_top_data;
                o.npush = o.npush + 2'd1;
            end
            if (res_valid) begin
                o.nres  = o.nres + 2'd1;
                o.rdata = res_data;
            end
            if ((code != 3'd0 && code != 3'd1 && code != 3'd2 && code != 3'd4) ||
                push_pen || push_pen_data !== '0)
                o.multi = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, push_top, push_pen, pop_top, pop_pen, res_valid, err} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {in_ready, push_top, push_pen, pop_top, pop_pen, res_valid, err});
        end
        vectors++;
        if ({depth, res_data, push_top_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: depth %h res %h ptd %h want all 0", depth, res_data, push_top_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sub_seq();
        logic [11:0] tbl[3] = '{12'h105, 12'h103, 12'h400};
        obs_t o, e;
        for (int i = 0; i < 3; i++) begin
            model(tbl[i][10:8], tbl[i][7:0], tbl[i][11], e);
            run_op(tbl[i][10:8], tbl[i][7:0], tbl[i][11], o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL sub_seq[%0d] activity: got %h want %h", i, o, e); end
            vectors++;
            if (depth !== (D+1)'(ref_q.size())) begin miscompares++; $display("FAIL sub_seq[%0d] depth: got %0d want %0d", i, depth, ref_q.size()); end
        end
    endtask

    task automatic test_alu();
        logic [11:0] tbl[9] = '{12'h1F0, 12'h120, 12'h300, 12'h1F0, 12'h13C, 12'h500,
                                12'h1FF, 12'h10F, 12'h600};
        obs_t o, e;
        for (int i = 0; i < 9; i++) begin
            model(tbl[i][10:8], tbl[i][7:0], tbl[i][11], e);
            run_op(tbl[i][10:8], tbl[i][7:0], tbl[i][11], o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL alu[%0d] activity: got %h want %h", i, o, e); end
            vectors++;
            if (res_data !== ref_res) begin miscompares++; $display("FAIL alu[%0d] res_data: got %h want %h", i, res_data, ref_res); end
        end
    endtask

    task automatic test_errors();
        // drain, POP at 0, PUSH, ADD at 1, clear, illegal+clear (set wins), clear
        logic [11:0] tbl[6] = '{12'h200, 12'h155, 12'h300, 12'h800, 12'hB00, 12'h800};
        obs_t o, e;
        while (ref_q.size() > 0) begin
            model(3'd2, '0, 1'b0, e);
            run_op(3'd2, '0, 1'b0, o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL drain activity: got %h want %h", o, e); end
        end
        for (int i = 0; i < 6; i++) begin
            model(tbl[i][10:8], tbl[i][7:0], tbl[i][11], e);
            run_op(tbl[i][10:8], tbl[i][7:0], tbl[i][11], o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL errors[%0d] activity: got %h want %h", i, o, e); end
            vectors++;
            if ({err, depth} !== {ref_err, (D+1)'(ref_q.size())}) begin
                miscompares++;
                $display("FAIL errors[%0d] err/depth: got %b/%0d want %b/%0d", i, err, depth, ref_err, ref_q.size());
            end
        end
    endtask

    task automatic test_full();
        logic [11:0] tbl[4] = '{12'h1AA, 12'h700, 12'h800, 12'h200};
        logic [W-1:0] v;
        obs_t o, e;
        while (ref_q.size() < DMAX) begin
            v = W'($urandom);
            model(3'd1, v, 1'b0, e);
            run_op(3'd1, v, 1'b0, o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL fill activity: got %h want %h", o, e); end
        end
        for (int i = 0; i < 4; i++) begin
            model(tbl[i][10:8], tbl[i][7:0], tbl[i][11], e);
            run_op(tbl[i][10:8], tbl[i][7:0], tbl[i][11], o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL full[%0d] activity: got %h want %h", i, o, e); end
            vectors++;
            if ({err, depth} !== {ref_err, (D+1)'(ref_q.size())}) begin
                miscompares++;
                $display("FAIL full[%0d] err/depth: got %b/%0d want %b/%0d", i, err, depth, ref_err, ref_q.size());
            end
        end
    endtask

    task automatic test_dup();
        logic [11:0] tbl[2] = '{12'h17A, 12'h700};
        obs_t o, e;
        while (ref_q.size() > 0) begin
            model(3'd2, '0, 1'b0, e);
            run_op(3'd2, '0, 1'b0, o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL dup_drain activity: got %h want %h", o, e); end
        end
        for (int i = 0; i < 2; i++) begin
            model(tbl[i][10:8], tbl[i][7:0], tbl[i][11], e);
            run_op(tbl[i][10:8], tbl[i][7:0], tbl[i][11], o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL dup[%0d] activity: got %h want %h", i, o, e); end
            vectors++;
            if (depth !== (D+1)'(ref_q.size())) begin miscompares++; $display("FAIL dup[%0d] depth: got %0d want %0d", i, depth, ref_q.size()); end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] tbl[9] = '{12'h111, 12'h122, 12'h300, 12'h700, 12'h200,
                                12'h600, 12'h000, 12'h144, 12'h400};
        obs_t e;
        int cycles, exp_cycles, exp_push, push0;
        cycles = 0; exp_cycles = 0; exp_push = 0;
        push0 = push_cnt;
        in_op = tbl[0][10:8]; in_imm = tbl[0][7:0]; in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            model(tbl[i][10:8], tbl[i][7:0], 1'b0, e);
            exp_cycles += int'(e.busy) + 1;
            exp_push   += int'(e.npush);
            @(posedge clk);
            #1;
            if (i < 8) begin
                in_op = tbl[i+1][10:8]; in_imm = tbl[i+1][7:0];
            end else begin
                in_valid = 1'b0;
            end
            do begin
                @(negedge clk);
                cycles++;
            end while (!in_ready && cycles < 200);
        end
        in_valid = 1'b0;
        vectors++;
        if (cycles !== exp_cycles) begin miscompares++; $display("FAIL b2b cycles: got %0d want %0d", cycles, exp_cycles); end
        vectors++;
        if (push_cnt - push0 !== exp_push) begin miscompares++; $display("FAIL b2b pushes: got %0d want %0d", push_cnt - push0, exp_push); end
        vectors++;
        if ({err, depth} !== {ref_err, (D+1)'(ref_q.size())}) begin
            miscompares++;
            $display("FAIL b2b err/depth: got %b/%0d want %b/%0d", err, depth, ref_err, ref_q.size());
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        if (ref_q.size() < 2) begin
            model(3'd1, 8'h01, 1'b0, e); run_op(3'd1, 8'h01, 1'b0, o);
            model(3'd1, 8'h02, 1'b0, e); run_op(3'd1, 8'h02, 1'b0, o);
        end
        in_op = 3'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2;
        vectors++;
        if (pop_pen !== 1'b1) begin miscompares++; $display("FAIL rst_mid pre pop_pen: got %b want 1", pop_pen); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({push_top, pop_top, pop_pen, res_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_mid strobes: got %b want 0000", {push_top, pop_top, pop_pen, res_valid});
        end
        vectors++;
        if ({err, depth} !== '0) begin miscompares++; $display("FAIL rst_mid err/depth: got %b/%0d want 0/0", err, depth); end
        @(negedge clk);
        rst_n = 1'b1;
        ref_q.delete(); ref_err = 1'b0; ref_res = '0;
        @(negedge clk);
        vectors++;
        if ({in_ready, push_top, pop_top, pop_pen} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rst_mid release: got %b want 1000", {in_ready, push_top, pop_top, pop_pen});
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [W-1:0] imm;
        logic clr;
        obs_t o, e;
        for (int i = 0; i < 200; i++) begin
            op  = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            imm = W'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            model(op, imm, clr, e);
            run_op(op, imm, clr, o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rand[%0d] op%0d activity: got %h want %h", i, op, o, e); end
            vectors++;
            if ({err, depth, res_data} !== {ref_err, (D+1)'(ref_q.size()), ref_res}) begin
                miscompares++;
                $display("FAIL rand[%0d] op%0d err/depth/res: got %b/%0d/%h want %b/%0d/%h",
                         i, op, err, depth, res_data, ref_err, ref_q.size(), ref_res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub_seq();
        test_alu();
        test_errors();
        test_full();
        test_dup();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Instruction front-end that drives the two-slot operand stack (push_top/push_pen/pop_top/pop_pen, topVal/penVal) directly downstream.
- Accepts 3-bit stack-machine ops over a valid/ready handshake and sequences them into single-cycle stack strobes.
- Samples the stack's registered outputs to compute ALU results, tracks depth, and flags overflow/underflow.

Parameters:
W, 8, data width; must match the downstream stack.
D, 5, log2 stack capacity; max depth DMAX = 2**D.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  sequencer idle, can accept
in_op  in  3  opcode: 000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 XOR, 111 DUP
in_imm  in  W  immediate for PUSH
top_val  in  W  stack topVal
pen_val  in  W  stack penVal
push_top  out  1  stack strobe
push_pen  out  1  stack strobe; tied 0
pop_top  out  1  stack strobe
pop_pen  out  1  stack strobe
push_top_data  out  W  data for push_top
push_pen_data  out  W  tied 0
res_valid  out  1  one-cycle result pulse
res_data  out  W  result for POP/ALU ops
depth  out  D+1  current entry count, 0..DMAX
err  out  1  sticky overflow/underflow flag
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async, rst_n=0): state IDLE, depth=0, err=0, res_valid=0, res_data=0, all strobes 0, push_top_data=0. Reset mid-sequence aborts the sequence with no further strobes. Stack contents are treated as invalid after reset.
- Handshake: in_ready=1 only in IDLE. An instruction is accepted on a rising edge where in_valid && in_ready. in_op and in_imm are captured at acceptance.
- Strobes are registered state decodes. At most one strobe is high per cycle. Each stack command is issued for exactly one cycle.
- Legality check at acceptance:
  - PUSH needs depth<DMAX.
  - POP needs depth>=1.
  - ADD/SUB/AND/XOR need depth>=2.
  - DUP needs 1<=depth<DMAX.
  - An illegal op sets err=1, issues no strobes, and the FSM stays IDLE (in_ready stays 1).
  - NOP is accepted with no effect.
- States: IDLE, PUSH, POP_T, POP_P, WAIT, EXEC, DUP_A, DUP_B. Acceptance at edge t puts the first post-IDLE state in cycle t+1.
- PUSH: cycle t+1 push_top=1, push_top_data=imm, depth+1; t+2 IDLE.
- POP: t+1 POP_T (pop_top=1, depth-1); t+2 WAIT; t+3 EXEC (res_valid=1, res_data=top_val, no push); t+4 IDLE.
- ALU ops:
  - t+1 POP_T (pop_top); t+2 POP_P (pop_pen); t+3 WAIT.
  - t+4 EXEC: push_top=1, push_top_data=res_data=f(pen_val,top_val), res_valid=1.
  - Net depth change -1 (-2 at pops, +1 at push). t+5 IDLE.
- ALU arithmetic: ADD = pen+top; SUB = pen-top; both mod 2**W, carry/borrow dropped. AND and XOR are bitwise.
- DUP: t+1 POP_T (pop_top, depth-1); t+2 WAIT; t+3 DUP_A (push_top, data=top_val captured into a holding register this cycle, depth+1); t+4 DUP_B (push_top with held value, depth+1); t+5 IDLE. No res_valid.
- depth updates on the same edge that ends the strobe cycle. It never wraps, because the legality check guarantees this.
- err:
  - Set by an illegal acceptance.
  - Cleared by err_clr only when no illegal acceptance occurs in the same cycle (set wins).
  - err does not block subsequent instructions.
- res_valid is high for exactly one cycle. res_data holds its value until the next result.

Test Plan:
- Reset, then PUSH 0x05 and PUSH 0x03, then SUB -> push_top strobes carry 0x05, 0x03; SUB gives pop_top, pop_pen, WAIT, then push_top with data 0x02, res_data=0x02; depth 1->2->1; in_ready returns 5 cycles after SUB acceptance.
- PUSH 0xF0, PUSH 0x20, ADD -> result 0x10 (carry dropped); AND on 0xF0/0x3C -> 0x30; XOR on 0xFF/0x0F -> 0xF0.
- From depth 0: POP -> err=1, no strobes, in_ready stays 1, depth 0. ADD at depth 1 -> err=1, depth remains 1. err_clr with no error -> err=0.
- Push 32 values (depth=32), then a 33rd PUSH -> err=1, push_top never asserted. DUP at depth 32 -> err. POP -> res_data equals the last pushed value, depth=31.
- PUSH 0x7A, DUP -> pop_top, WAIT, then two push_top strobes with 0x7A; depth 1->0->1->2; no res_valid.
- Assert rst_n=0 during ALU op POP_P -> all strobes drop immediately, depth=0, err=0, in_ready=1 after release. Back-to-back instructions with in_valid held high -> each accepted only when in_ready=1, never mid-sequence.
